loop_index_ctrl: RTL

Sequential loop-index controller for HLS-generated datapaths. Holds the loop index register and drives it to the downstream incrementer, then latches the incremented value back after each loop-body completion. It sequences a `for (i = Lo; i < Hi; i++)` loop with a Start/Done handshake toward the scheduler and a BodyStart/BodyDone handshake toward the loop-body datapath.

---
 rtl/loop_index_ctrl_pkg.sv | 15 +
 rtl/loop_index_ctrl_fsm.sv | 57 +++++
 rtl/loop_index_ctrl.sv | 72 +++++++
 3 files changed

// File: rtl/loop_index_ctrl_pkg.sv
// Shared HLS controller definitions.
// Holds the state encoding and the default index width.
package loop_index_ctrl_pkg;

    localparam int DEF_DATAWIDTH = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_BODY  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

endpackage

// File: rtl/loop_index_ctrl_fsm.sv
// Loop sequencer next-state logic and Moore output decode.
// Also flags the load and step strobes used by the datapath.
module loop_fsm
    import loop_index_ctrl_pkg::*;
(
    input  state_t i_state,
    input  logic   i_start,
    input  logic   i_lt,
    input  logic   i_body_done,
    output state_t o_next_state,
    output logic   o_load,
    output logic   o_step,
    output logic   o_body_start,
    output logic   o_done,
    output logic   o_busy
);

    always_comb begin
        o_next_state = i_state;
        o_load       = 1'b0;
        o_step       = 1'b0;
        o_body_start = 1'b0;
        o_done       = 1'b0;
        o_busy       = 1'b1;
        unique case (i_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    o_load       = 1'b1;
                    o_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                o_next_state = i_lt ? ST_BODY : ST_FIN;
            end
            ST_BODY: begin
                o_body_start = 1'b1;
                o_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_body_done) begin
                    o_step       = 1'b1;
                    o_next_state = ST_CHECK;
                end
            end
            ST_FIN: begin
                o_done       = 1'b1;
                o_next_state = ST_IDLE;
            end
            default: begin
                o_busy       = 1'b0;
                o_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/loop_index_ctrl.sv
// Loop index controller: index/bound/count registers and comparator.
// The index incrementer sits outside and returns NextIdx.
module loop_index_ctrl
    import loop_index_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [DATAWIDTH-1:0] Lo,
    input  logic [DATAWIDTH-1:0] Hi,
    input  logic [DATAWIDTH-1:0] NextIdx,
    input  logic                 BodyDone,
    output logic [DATAWIDTH-1:0] Idx,
    output logic                 BodyStart,
    output logic                 Busy,
    output logic                 Done,
    output logic [DATAWIDTH-1:0] Iters
);

    localparam logic [DATAWIDTH-1:0] ONE = DATAWIDTH'(1);

    state_t               r_state;
    state_t               w_next_state;
    logic [DATAWIDTH-1:0] r_idx;
    logic [DATAWIDTH-1:0] r_bound;
    logic [DATAWIDTH-1:0] r_iters;
    logic                 w_lt;
    logic                 w_load;
    logic                 w_step;

    assign w_lt = (r_idx < r_bound);

    loop_fsm u_fsm (
        .i_state      (r_state),
        .i_start      (Start),
        .i_lt         (w_lt),
        .i_body_done  (BodyDone),
        .o_next_state (w_next_state),
        .o_load       (w_load),
        .o_step       (w_step),
        .o_body_start (BodyStart),
        .o_done       (Done),
        .o_busy       (Busy)
    );

    // Idx only moves on load or an accepted BodyDone, so it is
    // stable across the whole BODY/WAIT window.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_bound <= '0;
            r_iters <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_idx   <= Lo;
                r_bound <= Hi;
                r_iters <= '0;
            end else if (w_step) begin
                r_idx   <= NextIdx;
                r_iters <= r_iters + ONE;
            end
        end
    end

    assign Idx   = r_idx;
    assign Iters = r_iters;

endmodule
